set_map_scanner: RTL
====================

SET_MAP_SCANNER -- requirements
Module: set_map_scanner

Interface
REQ-001 SHALL have parameter DATA_X_W, default 7: bitmap row width (X dimension, bit 0 = LSB scanned first).
REQ-002 SHALL have parameter DATA_Y_W, default 5: bitmap row count (Y dimension, row 0 scanned first).
REQ-003 SHALL have port Clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port Rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-005 SHALL have port Flush, input, 1: synchronous abort of the current map.
REQ-006 SHALL have port MapValid, input, 1: MapIn valid.
REQ-007 SHALL have port MapReady, output, 1: block accepts a new map.
REQ-008 SHALL have port MapIn, input, [DATA_X_W-1:0] x DATA_Y_W (unpacked by row): bitmap to scan.
REQ-009 SHALL have port CoordValid, output, 1: coordinate presented.
REQ-010 SHALL have port CoordReady, input, 1: consumer accepts coordinate.
REQ-011 SHALL have port CoordOhX, output, DATA_X_W: one-hot column of current first set bit.
REQ-012 SHALL have port CoordOhY, output, DATA_Y_W: one-hot row of current first set bit.
REQ-013 SHALL have port CoordX, output, $clog2(DATA_X_W): binary column index of CoordOhX.
REQ-014 SHALL have port CoordY, output, $clog2(DATA_Y_W): binary row index of CoordOhY.
REQ-015 SHALL have port CoordLast, output, 1: current coordinate is the last set bit of the map.
REQ-016 SHALL have port CoordIdx, output, $clog2(DATA_X_W*DATA_Y_W+1): count of coordinates already accepted for this map.
REQ-017 SHALL have port Done, output, 1: one-cycle pulse when a map is fully drained or found empty.

Function
REQ-018 SHALL implement two states: IDLE, SCAN.
REQ-019 IDLE: MapReady=1, CoordValid=0; on MapValid, SHALL register MapIn into the internal map register and clear CoordIdx.
REQ-020 IDLE accept of an all-zero map: SHALL stay IDLE and pulse Done in the following cycle; no coordinate issued.
REQ-021 IDLE accept of a non-zero map: SHALL enter SCAN; CoordValid asserted the cycle after acceptance (latency 1).
REQ-022 SCAN: MapReady=0, CoordValid=1; MapValid ignored, not consumed.
REQ-023 SCAN: coordinate outputs SHALL be combinational from the map register: first set row from row 0 upward, then first set bit in that row from LSB upward.
REQ-024 CoordOhX/CoordOhY SHALL each be exactly one-hot while CoordValid=1 and all-zero while CoordValid=0; CoordX/CoordY SHALL be 0 while CoordValid=0.
REQ-025 CoordLast SHALL be 1 iff the map register with the current bit cleared is all zero.
REQ-026 Handshake (CoordValid & CoordReady) SHALL clear exactly the current bit in the map register and increment CoordIdx by 1.
REQ-027 While CoordValid=1 and CoordReady=0, all Coord* outputs and CoordIdx SHALL hold stable.
REQ-028 Handshake with CoordLast=1 SHALL return to IDLE; Done SHALL pulse the next cycle; MapReady=1 that same next cycle.
REQ-029 Back-to-back: with CoordReady held 1, one coordinate SHALL be accepted per cycle, no bubbles.
REQ-030 Flush SHALL take priority over all other events: map register cleared, CoordIdx cleared, state IDLE next cycle, no Done pulse, any concurrent handshake or MapValid discarded.
REQ-031 CoordIdx SHALL never wrap; maximum value is DATA_X_W*DATA_Y_W.

Reset
REQ-032 While Rst_n=0: state IDLE, map register all zero, CoordIdx=0, Done=0, CoordValid=0; MapReady=1 after Rst_n deasserts.
REQ-033 Reset asserted mid-SCAN SHALL immediately abandon the map; no Done pulse follows release.

Verification
REQ-034 Defaults; rows 0..4 = 0x00,0x04,0x02,0x0C,0x00, CoordReady=1 -> coordinates (X,Y) = (2,1),(1,2),(2,3),(3,3) on consecutive cycles, CoordIdx 0..3, CoordLast only on (3,3), Done next cycle.
REQ-035 Same map, CoordReady held 0 for 3 cycles after CoordValid -> (2,1) held stable 3 cycles, CoordIdx=0, map unchanged.
REQ-036 All-zero map accepted -> CoordValid never asserts, Done pulses exactly one cycle after acceptance.
REQ-037 All 35 bits set, CoordReady=1 -> 35 coordinates in raster order (0,0),(1,0),...,(6,4), final CoordIdx=35, Done once.
REQ-038 Flush asserted on the cycle of second handshake -> IDLE next cycle, MapReady=1, CoordIdx=0, no Done; new map then scans from its own first bit.
REQ-039 Rst_n pulsed low mid-SCAN -> CoordValid=0 asynchronously, MapReady=1 after release, no Done.

Source files
------------

// File: rtl/set_map_scanner.sv
// Bitmap scanner: accepts a DATA_Y_W x DATA_X_W bitmap and emits the coordinates of its
// set bits in raster order (row 0 first, LSB first) over a valid/ready handshake.
module set_map_scanner #(
  parameter int DATA_X_W = 7,
  parameter int DATA_Y_W = 5
) (
  input  logic                                        Clk,
  input  logic                                        Rst_n,
  input  logic                                        Flush,
  input  logic                                        MapValid,
  output logic                                        MapReady,
  input  logic [DATA_X_W-1:0]                         MapIn [DATA_Y_W],
  output logic                                        CoordValid,
  input  logic                                        CoordReady,
  output logic [DATA_X_W-1:0]                         CoordOhX,
  output logic [DATA_Y_W-1:0]                         CoordOhY,
  output logic [((DATA_X_W > 1) ? $clog2(DATA_X_W) : 1)-1:0] CoordX,
  output logic [((DATA_Y_W > 1) ? $clog2(DATA_Y_W) : 1)-1:0] CoordY,
  output logic                                        CoordLast,
  output logic [$clog2(DATA_X_W*DATA_Y_W+1)-1:0]      CoordIdx,
  output logic                                        Done
);

  localparam int N   = DATA_X_W * DATA_Y_W;
  localparam int XIW = (DATA_X_W > 1) ? $clog2(DATA_X_W) : 1;
  localparam int YIW = (DATA_Y_W > 1) ? $clog2(DATA_Y_W) : 1;
  localparam int IW  = $clog2(N + 1);
  localparam logic [N-1:0]  ONE_N   = N'(1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);
  localparam logic [IW-1:0] IDX_MAX = IW'(N);

  typedef enum logic [0:0] {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   map_q, map_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           done_q, done_d;

  logic [N-1:0]        map_in_flat_s;
  logic [N-1:0]        oh_flat_s;
  logic                last_s;
  logic                valid_s;
  logic [DATA_X_W-1:0] ohx_s;
  logic [DATA_Y_W-1:0] ohy_s;
  logic [XIW-1:0]      cx_s;
  logic [YIW-1:0]      cy_s;

  // Flatten the row-indexed input so raster order equals flat bit order.
  always_comb begin
    map_in_flat_s = '0;
    for (int y = 0; y < DATA_Y_W; y++) begin
      map_in_flat_s[y*DATA_X_W +: DATA_X_W] = MapIn[y];
    end
  end

  // Lowest set flat bit is the next raster coordinate; decode it into X/Y views.
  always_comb begin
    oh_flat_s = map_q & (~map_q + ONE_N);
    last_s    = ((map_q & ~oh_flat_s) == '0);
    ohx_s     = '0;
    ohy_s     = '0;
    cx_s      = '0;
    cy_s      = '0;
    for (int y = 0; y < DATA_Y_W; y++) begin
      for (int x = 0; x < DATA_X_W; x++) begin
        ohx_s[x] = ohx_s[x] | oh_flat_s[y*DATA_X_W + x];
        ohy_s[y] = ohy_s[y] | oh_flat_s[y*DATA_X_W + x];
        cx_s     = cx_s | ({XIW{oh_flat_s[y*DATA_X_W + x]}} & XIW'(x));
        cy_s     = cy_s | ({YIW{oh_flat_s[y*DATA_X_W + x]}} & YIW'(y));
      end
    end
  end

  // Coordinate outputs are forced to zero whenever no coordinate is presented.
  always_comb begin
    valid_s    = (state_q == SCAN);
    CoordValid = valid_s;
    MapReady   = (state_q == IDLE);
    CoordIdx   = idx_q;
    Done       = done_q;
    if (valid_s) begin
      CoordOhX  = ohx_s;
      CoordOhY  = ohy_s;
      CoordX    = cx_s;
      CoordY    = cy_s;
      CoordLast = last_s;
    end else begin
      CoordOhX  = '0;
      CoordOhY  = '0;
      CoordX    = '0;
      CoordY    = '0;
      CoordLast = 1'b0;
    end
  end

  // Next-state logic; Flush overrides every other event and suppresses Done.
  always_comb begin
    state_d = state_q;
    map_d   = map_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (Flush) begin
      state_d = IDLE;
      map_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (MapValid) begin
            map_d = map_in_flat_s;
            idx_d = '0;
            if (map_in_flat_s == '0) begin
              done_d = 1'b1;
            end else begin
              state_d = SCAN;
            end
          end else begin
            state_d = IDLE;
          end
        end
        SCAN: begin
          if (CoordReady) begin
            map_d = map_q & ~oh_flat_s;
            idx_d = (idx_q == IDX_MAX) ? idx_q : (idx_q + IDX_ONE);
            if (last_s) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = SCAN;
            end
          end else begin
            state_d = SCAN;
          end
        end
        default: begin
          state_d = IDLE;
          map_d   = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      map_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      map_q   <= map_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

endmodule
